// File: rtl/reservoir_ctrl_p.sv
// Reservoir release controller: level, spill-forced release, energy
// accounting and a NORMAL/FLOOD/DROUGHT mode machine.
module reservoir_ctrl_p #(
    parameter int W           = 8,
    parameter int REQ_SHIFT   = 2,
    parameter int SPILL_LEVEL = 16,
    parameter int LOW_LEVEL   = 4,
    parameter int DRY_CYCLES  = 3,
    parameter int GAIN_SHIFT  = 2,
    parameter int ACC_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [W-1:0]          rain,
    input  logic [W-1:0]          req,
    output logic [W-1:0]          out,
    output logic [W-1:0]          now,
    output logic [W+GAIN_SHIFT-1:0] electric,
    output logic                  out_valid,
    output logic                  spill,
    output logic [1:0]            mode,
    output logic [ACC_W-1:0]      energy_total
);

    localparam int EW  = W + GAIN_SHIFT;
    localparam int DCW = $clog2(DRY_CYCLES + 1);

    localparam logic [W-1:0]   ONES    = '1;
    localparam logic [W-1:0]   LO_MASK = ~(ONES << REQ_SHIFT);
    localparam logic [W-1:0]   SPILL_W = W'(SPILL_LEVEL);
    localparam logic [W-1:0]   LOW_W   = W'(LOW_LEVEL);
    localparam logic [DCW-1:0] DRY_MAX = DCW'(DRY_CYCLES);

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        FLOOD   = 2'd1,
        DROUGHT = 2'd2
    } mode_e;

    mode_e            mode_q, mode_d;
    logic [W-1:0]     out_q, out_d;
    logic [W-1:0]     now_q, now_d;
    logic [EW-1:0]    elec_q, elec_d;
    logic             out_valid_q, out_valid_d;
    logic             spill_q, spill_d;
    logic [ACC_W-1:0] energy_q, energy_d;
    logic [DCW-1:0]   dry_q, dry_d;

    logic             ration;
    logic [W:0]       sum;
    logic             sat;
    logic [W-1:0]     lvl;
    logic [W-1:0]     mreq;
    logic [W-1:0]     mreq_eff;
    logic [W-1:0]     base;
    logic [W-1:0]     rem;
    logic [W-1:0]     excess;
    logic [W-1:0]     rel;
    logic [W-1:0]     new_lvl;
    logic [EW-1:0]    elec_w;
    logic             spill_evt;
    logic [ACC_W:0]   e_sum;
    logic [DCW-1:0]   dry_next;

    // Release datapath, evaluated against the registered level and mode
    always_comb begin
        sum      = {1'b0, now_q} + {1'b0, rain};
        sat      = sum[W];
        lvl      = sat ? ONES : sum[W-1:0];
        mreq     = (req >> REQ_SHIFT) + W'(|(req & LO_MASK));
        mreq_eff = ration ? (mreq >> 1) : mreq;
        base     = (lvl < mreq_eff) ? lvl : mreq_eff;
        rem      = lvl - base;
        excess   = (rem >= SPILL_W) ? (rem - SPILL_W) : '0;
        rel      = base + excess;
        new_lvl  = rem - excess;
        elec_w   = EW'(rel) << GAIN_SHIFT;
        spill_evt = (|excess) | sat;
        e_sum    = {1'b0, energy_q} + (ACC_W+1)'(elec_w);
        if (new_lvl < LOW_W) begin
            dry_next = (dry_q == DRY_MAX) ? dry_q : dry_q + DCW'(1);
        end else begin
            dry_next = '0;
        end
    end

    always_comb begin
        out_d       = out_q;
        now_d       = now_q;
        elec_d      = elec_q;
        energy_d    = energy_q;
        dry_d       = dry_q;
        out_valid_d = in_valid;
        spill_d     = 1'b0;
        if (in_valid) begin
            out_d    = rel;
            now_d    = new_lvl;
            elec_d   = elec_w;
            spill_d  = spill_evt;
            dry_d    = dry_next;
            energy_d = e_sum[ACC_W] ? {ACC_W{1'b1}} : e_sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            now_q       <= '0;
            elec_q      <= '0;
            out_valid_q <= 1'b0;
            spill_q     <= 1'b0;
            energy_q    <= '0;
            dry_q       <= '0;
        end else begin
            out_q       <= out_d;
            now_q       <= now_d;
            elec_q      <= elec_d;
            out_valid_q <= out_valid_d;
            spill_q     <= spill_d;
            energy_q    <= energy_d;
            dry_q       <= dry_d;
        end
    end

    // Mode machine: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= NORMAL;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Mode machine: next state, spill has top priority
    always_comb begin
        mode_d = mode_q;
        if (in_valid) begin
            if (spill_evt) begin
                mode_d = FLOOD;
            end else begin
                unique case (mode_q)
                    FLOOD:   mode_d = NORMAL;
                    NORMAL:  mode_d = (dry_next == DRY_MAX) ? DROUGHT : NORMAL;
                    DROUGHT: mode_d = (new_lvl >= LOW_W) ? NORMAL : DROUGHT;
                    default: mode_d = NORMAL;
                endcase
            end
        end
    end

    // Mode machine: outputs
    always_comb begin
        ration = (mode_q == DROUGHT);
        mode   = mode_q;
    end

    assign out          = out_q;
    assign now          = now_q;
    assign electric     = elec_q;
    assign out_valid    = out_valid_q;
    assign spill        = spill_q;
    assign energy_total = energy_q;

endmodule

// File: tb/tb_reservoir_ctrl_p.sv
// Bench for reservoir_ctrl_p: directed table, corner sequences and
// randomized samples against an arithmetic reference model.
module tb_reservoir_ctrl_p;

    localparam int W     = 8;
    localparam int RS    = 2;
    localparam int SPL   = 16;
    localparam int LOW   = 4;
    localparam int DRY   = 3;
    localparam int GS    = 2;
    localparam int ACC_W = 16;
    localparam int WMAX  = (1 << W) - 1;
    localparam int EMAX  = (1 << ACC_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic [W-1:0]       rain = '0;
    logic [W-1:0]       req = '0;
    logic [W-1:0]       out;
    logic [W-1:0]       now;
    logic [W+GS-1:0]    electric;
    logic               out_valid;
    logic               spill;
    logic [1:0]         mode;
    logic [ACC_W-1:0]   energy_total;

    reservoir_ctrl_p #(
        .W(W), .REQ_SHIFT(RS), .SPILL_LEVEL(SPL), .LOW_LEVEL(LOW),
        .DRY_CYCLES(DRY), .GAIN_SHIFT(GS), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .rain(rain), .req(req),
        .out(out), .now(now), .electric(electric), .out_valid(out_valid),
        .spill(spill), .mode(mode), .energy_total(energy_total)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    // Reference model state
    int m_now, m_mode, m_dry, m_energy;
    int x_out, x_elec, x_valid, x_spill;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_now = 0; m_mode = 0; m_dry = 0; m_energy = 0;
        x_out = 0; x_elec = 0; x_valid = 0; x_spill = 0;
    endtask

    task automatic model_step(input bit v, input int r, input int q);
        int lvl, mr, base, o;
        bit sat;
        x_valid = v;
        x_spill = 0;
        if (!v) return;
        sat  = (m_now + r) > WMAX;
        lvl  = sat ? WMAX : m_now + r;
        mr   = (q + (2 ** RS) - 1) / (2 ** RS);
        if (m_mode == 2) mr = mr / 2;
        base = (lvl < mr) ? lvl : mr;
        o    = (lvl - SPL > base) ? lvl - SPL : base;
        x_out   = o;
        m_now   = lvl - o;
        x_spill = (o > base) || sat;
        x_elec  = o * (2 ** GS);
        m_energy = (m_energy + x_elec > EMAX) ? EMAX : m_energy + x_elec;
        m_dry = (m_now < LOW) ? ((m_dry + 1 > DRY) ? DRY : m_dry + 1) : 0;
        if (x_spill) m_mode = 1;
        else if (m_mode == 1) m_mode = 0;
        else if (m_mode == 0 && m_dry == DRY) m_mode = 2;
        else if (m_mode == 2 && m_now >= LOW) m_mode = 0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".out"}, int'(out), x_out);
        chk({tag, ".now"}, int'(now), m_now);
        chk({tag, ".electric"}, int'(electric), x_elec);
        chk({tag, ".out_valid"}, int'(out_valid), x_valid);
        chk({tag, ".spill"}, int'(spill), x_spill);
        chk({tag, ".mode"}, int'(mode), m_mode);
        chk({tag, ".energy"}, int'(energy_total), m_energy);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Inputs change 1 time unit after an edge; outputs sampled likewise
    task automatic step(input bit v, input int r, input int q);
        in_valid = v;
        rain = W'(r);
        req = W'(q);
        @(posedge clk);
        #1;
        model_step(v, r, q);
    endtask

    typedef struct {
        bit rst_b;
        int rain;
        int req;
        int e_out;
        int e_now;
        int e_elec;
        int e_spill;
        int e_mode;
        int e_en;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1, 10,  20,   5,  5,  20, 0, 0,  20};
        tbl[1] = '{1,  3,   5,   2,  1,   8, 0, 0,   8};
        tbl[2] = '{1, 40,   8,  24, 16,  96, 1, 1,  96};
        tbl[3] = '{0,  0,   8,   2, 14,   8, 0, 0, 104};
        tbl[4] = '{1,  1,  40,   1,  0,   4, 0, 0,   4};
        tbl[5] = '{0,  1,  40,   1,  0,   4, 0, 0,   8};
        tbl[6] = '{0,  1,  40,   1,  0,   4, 0, 2,  12};
        tbl[7] = '{0, 20,  40,   5, 15,  20, 0, 0,  32};
        tbl[8] = '{0,  1,   0,   0, 16,   0, 0, 0,  32};
        tbl[9] = '{0, 255,  0, 239, 16, 956, 1, 1, 988};

        model_reset();
        rst = 1'b1;
        #3;
        chk("reset.out", int'(out), 0);
        chk("reset.now", int'(now), 0);
        chk("reset.energy", int'(energy_total), 0);
        chk("reset.mode", int'(mode), 0);
        chk("reset.out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            string t;
            t = $sformatf("tbl%0d", i);
            if (tbl[i].rst_b) do_reset();
            step(1'b1, tbl[i].rain, tbl[i].req);
            chk({t, ".out"}, int'(out), tbl[i].e_out);
            chk({t, ".now"}, int'(now), tbl[i].e_now);
            chk({t, ".electric"}, int'(electric), tbl[i].e_elec);
            chk({t, ".out_valid"}, int'(out_valid), 1);
            chk({t, ".spill"}, int'(spill), tbl[i].e_spill);
            chk({t, ".mode"}, int'(mode), tbl[i].e_mode);
            chk({t, ".energy"}, int'(energy_total), tbl[i].e_en);
        end

        // Idle cycles hold everything and clear the pulses
        for (int i = 0; i < 5; i++) begin
            step(1'b0, $urandom_range(0, WMAX), $urandom_range(0, WMAX));
            check_model("hold");
        end
        chk("hold.now_const", int'(now), 16);
        chk("hold.energy_const", int'(energy_total), 988);

        // Asynchronous reset pulse between edges
        #2;
        rst = 1'b1;
        #1;
        chk("arst.out", int'(out), 0);
        chk("arst.now", int'(now), 0);
        chk("arst.electric", int'(electric), 0);
        chk("arst.energy", int'(energy_total), 0);
        chk("arst.mode", int'(mode), 0);
        chk("arst.spill", int'(spill), 0);
        chk("arst.out_valid", int'(out_valid), 0);
        #1;
        rst = 1'b0;
        model_reset();

        // Repeated saturating samples drive the accumulator to its ceiling
        for (int i = 0; i < 72; i++) begin
            step(1'b1, 255, 0);
            check_model("esat");
        end
        chk("esat.ceiling", int'(energy_total), EMAX);

        do_reset();
        for (int i = 0; i < 400; i++) begin
            int r, q, k;
            bit v;
            v = ($urandom_range(0, 9) < 8);
            k = $urandom_range(0, 3);
            if (k == 0) r = $urandom_range(0, 2);
            else if (k == 1) r = $urandom_range(180, 255);
            else r = $urandom_range(0, 40);
            q = $urandom_range(0, WMAX);
            step(v, r, q);
            check_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
